// File: rtl/sap_cpu_pkg.sv
`default_nettype none
// ============================================================================
// sap_cpu_pkg : opcodes, FSM state type and per-opcode final-state lookup
// Revision    : 1.0
// ============================================================================
package sap_cpu_pkg;

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_lda = 4'h1;
    localparam logic [3:0] c_op_add = 4'h2;
    localparam logic [3:0] c_op_sub = 4'h3;
    localparam logic [3:0] c_op_sta = 4'h4;
    localparam logic [3:0] c_op_ldi = 4'h5;
    localparam logic [3:0] c_op_jmp = 4'h6;
    localparam logic [3:0] c_op_jc  = 4'h7;
    localparam logic [3:0] c_op_jz  = 4'h8;
    localparam logic [3:0] c_op_out = 4'hE;
    localparam logic [3:0] c_op_hlt = 4'hF;

    typedef enum logic [2:0] {
        ST_STOP = 3'd0,
        ST_F1   = 3'd1,
        ST_F2   = 3'd2,
        ST_E1   = 3'd3,
        ST_E2   = 3'd4,
        ST_E3   = 3'd5,
        ST_HALT = 3'd6
    } state_t;

    // Execute state that ends the instruction; unknown opcodes behave as NOP.
    function automatic state_t last_state(input logic [3:0] op);
        case (op)
            c_op_lda, c_op_sta: return ST_E2;
            c_op_add, c_op_sub: return ST_E3;
            default:            return ST_E1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sap_alu.sv
`default_nettype none
// ============================================================================
// sap_alu : combinational DATA_W adder/subtractor with carry and zero
// Revision: 1.0
// ============================================================================
module sap_alu #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] w_b_eff;
    logic [DATA_W:0]   w_sum;

    // Subtract as A + ~B + 1 so carry reads as "no borrow".
    assign w_b_eff = sub ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{DATA_W{1'b0}}, sub};
    assign result  = w_sum[DATA_W-1:0];
    assign carry   = w_sum[DATA_W];
    assign zero    = (w_sum[DATA_W-1:0] == '0);

endmodule
`default_nettype wire

// File: rtl/sap_cpu_core.sv
`default_nettype none
// ============================================================================
// sap_cpu_core : parametrised SAP-style accumulator CPU with loadable RAM
// Revision     : 1.0
// ============================================================================
module sap_cpu_core
    import sap_cpu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_value,
    output logic              out_valid,
    output logic              halted,
    output logic              running,
    output logic              carry,
    output logic              zero,
    output logic [ADDR_W-1:0] pc
);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_mar;
    logic [DATA_W-1:0] r_ir;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_out_valid;
    logic              r_carry;
    logic              r_zero;
    logic [DATA_W-1:0] r_ram [2**ADDR_W];

    logic [3:0]        w_opcode;
    logic [ADDR_W-1:0] w_operand;
    logic [DATA_W-1:0] w_ram_rd;
    logic [DATA_W-1:0] w_alu_res;
    logic              w_alu_carry;
    logic              w_alu_zero;
    logic              w_idle;
    logic              w_sta_we;
    logic              w_ram_we;
    logic [ADDR_W-1:0] w_ram_waddr;
    logic [DATA_W-1:0] w_ram_wdata;

    assign w_opcode  = r_ir[DATA_W-1 -: 4];
    assign w_operand = r_ir[ADDR_W-1:0];
    assign w_ram_rd  = r_ram[r_mar];

    sap_alu #(.DATA_W(DATA_W)) u_alu (
        .a      (r_a),
        .b      (r_b),
        .sub    (w_opcode == c_op_sub),
        .result (w_alu_res),
        .carry  (w_alu_carry),
        .zero   (w_alu_zero)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_STOP: if (run) w_next = ST_F1;
            ST_F1:   w_next = ST_F2;
            ST_F2:   w_next = ST_E1;
            ST_E1, ST_E2, ST_E3: begin
                if (w_opcode == c_op_hlt) begin
                    w_next = ST_HALT;
                end else if (r_state == last_state(w_opcode)) begin
                    w_next = run ? ST_F1 : ST_STOP;
                end else if (r_state == ST_E1) begin
                    w_next = ST_E2;
                end else begin
                    w_next = ST_E3;
                end
            end
            ST_HALT: if (!run) w_next = ST_STOP;
            default: w_next = ST_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc        <= '0;
            r_mar       <= '0;
            r_ir        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_carry     <= 1'b0;
            r_zero      <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                ST_F1: r_mar <= r_pc;
                ST_F2: begin
                    r_ir <= w_ram_rd;
                    r_pc <= r_pc + 1'b1;
                end
                ST_E1: begin
                    case (w_opcode)
                        c_op_lda, c_op_add, c_op_sub, c_op_sta: r_mar <= w_operand;
                        c_op_ldi: r_a <= {4'b0000, r_ir[DATA_W-5:0]};
                        c_op_jmp: r_pc <= w_operand;
                        c_op_jc:  if (r_carry) r_pc <= w_operand;
                        c_op_jz:  if (r_zero)  r_pc <= w_operand;
                        c_op_out: begin
                            r_out       <= r_a;
                            r_out_valid <= 1'b1;
                        end
                        c_op_nop: ;
                        default:  ;
                    endcase
                end
                ST_E2: begin
                    if (w_opcode == c_op_lda) begin
                        r_a <= w_ram_rd;
                    end else if (w_opcode == c_op_add || w_opcode == c_op_sub) begin
                        r_b <= w_ram_rd;
                    end
                end
                ST_E3: begin
                    if (w_opcode == c_op_add || w_opcode == c_op_sub) begin
                        r_a     <= w_alu_res;
                        r_carry <= w_alu_carry;
                        r_zero  <= w_alu_zero;
                    end
                end
                ST_HALT: if (!run) r_pc <= '0;
                default: ;
            endcase
        end
    end

    // RAM is deliberately outside reset so a loaded program survives it;
    // gating on rst_n keeps a reset edge from completing a pending store.
    assign w_idle      = (r_state == ST_STOP) || (r_state == ST_HALT);
    assign w_sta_we    = (r_state == ST_E2) && (w_opcode == c_op_sta);
    assign w_ram_we    = rst_n && (w_sta_we || (prog_we && w_idle));
    assign w_ram_waddr = w_sta_we ? r_mar : prog_addr;
    assign w_ram_wdata = w_sta_we ? r_a   : prog_data;

    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            r_ram[w_ram_waddr] <= w_ram_wdata;
        end
    end

    assign out_value = r_out;
    assign out_valid = r_out_valid;
    assign halted    = (r_state == ST_HALT);
    assign running   = !w_idle;
    assign carry     = r_carry;
    assign zero      = r_zero;
    assign pc        = r_pc;

endmodule
`default_nettype wire

// File: tb/tb_sap_cpu_core.sv
`default_nettype none
// ============================================================================
// tb_sap_cpu_core : directed self-checking bench for sap_cpu_core (8/4 and 12/8)
// Revision        : 1.0
// ============================================================================
module tb_sap_cpu_core;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run, prog_we;
    logic [3:0]  prog_addr;
    logic [7:0]  prog_data;
    logic [7:0]  out_value;
    logic        out_valid, halted, running, carry, zero;
    logic [3:0]  pc;

    logic        run2, prog_we2;
    logic [7:0]  prog_addr2;
    logic [11:0] prog_data2;
    logic [11:0] out_value2;
    logic        out_valid2, halted2, running2, carry2, zero2;
    logic [7:0]  pc2;

    int checks = 0;
    int errors = 0;
    logic [15:0] outs[$];
    logic [15:0] outs2[$];

    always #5 clk = ~clk;

    sap_cpu_core #(.DATA_W(8), .ADDR_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .prog_we(prog_we),
        .prog_addr(prog_addr), .prog_data(prog_data),
        .out_value(out_value), .out_valid(out_valid), .halted(halted),
        .running(running), .carry(carry), .zero(zero), .pc(pc)
    );

    sap_cpu_core #(.DATA_W(12), .ADDR_W(8)) dut_w (
        .clk(clk), .rst_n(rst_n), .run(run2), .prog_we(prog_we2),
        .prog_addr(prog_addr2), .prog_data(prog_data2),
        .out_value(out_value2), .out_valid(out_valid2), .halted(halted2),
        .running(running2), .carry(carry2), .zero(zero2), .pc(pc2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [3:0] addr, input logic [7:0] data);
        prog_addr = addr;
        prog_data = data;
        prog_we   = 1'b1;
        tick(1);
        prog_we   = 1'b0;
    endtask

    task automatic load2(input logic [7:0] addr, input logic [11:0] data);
        prog_addr2 = addr;
        prog_data2 = data;
        prog_we2   = 1'b1;
        tick(1);
        prog_we2   = 1'b0;
    endtask

    task automatic run_prog(input string tag, input int budget);
        int n;
        n   = 0;
        run = 1'b1;
        while (halted !== 1'b1 && n < budget) begin
            tick(1);
            n++;
            if (out_valid === 1'b1) outs.push_back(16'(out_value));
        end
        check({tag, "_halt"}, 32'(halted), 32'd1);
    endtask

    task automatic leave_halt();
        run = 1'b0;
        tick(1);
    endtask

    initial begin
        rst_n = 1'b0; run = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        run2 = 1'b0; prog_we2 = 1'b0; prog_addr2 = '0; prog_data2 = '0;
        tick(2);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_out", 32'(out_value), 32'd0);
        check("rst_flags", {30'd0, carry, zero}, 32'd0);
        check("rst_status", {29'd0, out_valid, halted, running}, 32'd0);
        rst_n = 1'b1;
        tick(1);

        // LDI 5 ; ADD [14] ; OUT ; HLT with exact cycle timing
        load(4'd0, 8'h55); load(4'd1, 8'h2E); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd14, 8'h03);
        run = 1'b1;
        tick(1);
        check("t1_running", 32'(running), 32'd1);
        tick(10);
        check("t1_no_valid_yet", 32'(out_valid), 32'd0);
        tick(1);
        check("t1_valid", 32'(out_valid), 32'd1);
        check("t1_value", 32'(out_value), 32'h08);
        tick(1);
        check("t1_pulse_end", {23'd0, out_valid, out_value}, 32'h008);
        tick(1);
        check("t1_not_halted", 32'(halted), 32'd0);
        tick(1);
        check("t1_halted", {30'd0, halted, running}, 32'b10);
        check("t1_pc", 32'(pc), 32'd4);
        check("t1_flags", {30'd0, carry, zero}, 32'd0);
        leave_halt();
        check("halt_to_stop_pc", {27'd0, halted, pc}, 32'd0);

        // 0xFF + 0x01 overflow
        load(4'd0, 8'h1E); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd14, 8'hFF); load(4'd15, 8'h01);
        outs.delete();
        run_prog("ovf", 40);
        check("ovf_out", outs.size() == 1 ? 32'(outs[0]) : 32'hDEAD, 32'h00);
        check("ovf_flags", {30'd0, carry, zero}, 32'b11);
        leave_halt();

        // 5 - 7 borrow
        load(4'd0, 8'h55); load(4'd1, 8'h3F); load(4'd15, 8'h07);
        outs.delete();
        run_prog("sub", 40);
        check("sub_out", outs.size() == 1 ? 32'(outs[0]) : 32'hDEAD, 32'hFE);
        check("sub_flags", {30'd0, carry, zero}, 32'b00);
        leave_halt();

        // JC/JZ not taken with carry=zero=0
        load(4'd0, 8'h79); load(4'd1, 8'h89); load(4'd2, 8'hF0);
        run_prog("nt", 40);
        check("nt_pc", 32'(pc), 32'd3);
        leave_halt();

        // Countdown 3,2,1 via SUB/JZ/JMP
        load(4'd0, 8'h53); load(4'd1, 8'hE0); load(4'd2, 8'h3F); load(4'd3, 8'h85);
        load(4'd4, 8'h61); load(4'd5, 8'hF0); load(4'd15, 8'h01);
        outs.delete();
        run_prog("cd", 120);
        check("cd_count", 32'(outs.size()), 32'd3);
        check("cd_seq", outs.size() == 3 ? {8'd0, outs[0][7:0], outs[1][7:0], outs[2][7:0]} : 32'hDEAD,
              32'h00030201);
        check("cd_flags", {30'd0, carry, zero}, 32'b11);
        leave_halt();

        // PC wrap: STA plants HLT at 0, JMP 15 runs NOP then wraps
        load(4'd0, 8'h1D); load(4'd1, 8'h40); load(4'd2, 8'h6F);
        load(4'd13, 8'hF0); load(4'd15, 8'h00);
        run_prog("wrap", 60);
        check("wrap_pc", 32'(pc), 32'd1);
        leave_halt();

        // run dropped during ADD E2
        load(4'd0, 8'h52); load(4'd1, 8'h2F); load(4'd2, 8'hE0); load(4'd3, 8'hF0);
        load(4'd15, 8'h03);
        run = 1'b1;
        tick(7);
        run = 1'b0;
        tick(2);
        check("drop_stopped", {30'd0, running, halted}, 32'd0);
        check("drop_pc", 32'(pc), 32'd2);
        tick(2);
        check("drop_pc_hold", {27'd0, running, pc}, 32'd2);
        run = 1'b1;
        tick(1);
        prog_addr = 4'd14; prog_data = 8'hAA; prog_we = 1'b1;
        tick(2);
        check("drop_resumed", 32'(running), 32'd1);
        prog_we = 1'b0;
        outs.delete();
        run_prog("resume", 40);
        check("resume_out", outs.size() == 1 ? 32'(outs[0]) : 32'hDEAD, 32'h05);
        load(4'd13, 8'h77);
        check("halt_stays", 32'(halted), 32'd1);
        leave_halt();
        load(4'd0, 8'h1E); load(4'd1, 8'hE0); load(4'd2, 8'h1D); load(4'd3, 8'hE0);
        load(4'd4, 8'hF0);
        outs.delete();
        run_prog("ram", 40);
        check("ram_run_we_ignored", outs.size() == 2 ? 32'(outs[0]) : 32'hDEAD, 32'hFF);
        check("ram_halt_we", outs.size() == 2 ? 32'(outs[1]) : 32'hDEAD, 32'h77);
        leave_halt();

        // Reset during STA E1
        load(4'd0, 8'h59); load(4'd1, 8'h4C); load(4'd2, 8'hF0); load(4'd12, 8'h33);
        run = 1'b1;
        tick(6);
        rst_n = 1'b0;
        run   = 1'b0;
        tick(2);
        check("mid_rst_pc", 32'(pc), 32'd0);
        check("mid_rst_out", {23'd0, out_valid, out_value}, 32'd0);
        check("mid_rst_status", {28'd0, halted, running, carry, zero}, 32'd0);
        rst_n = 1'b1;
        tick(1);
        load(4'd0, 8'h1C); load(4'd1, 8'hE0); load(4'd2, 8'hF0);
        outs.delete();
        run_prog("rst_ram", 40);
        check("rst_ram_kept", outs.size() == 1 ? 32'(outs[0]) : 32'hDEAD, 32'h33);
        leave_halt();

        // Wide instance: program at 200 reached by JMP
        load2(8'd0, 12'h6C8); load2(8'd200, 12'h5AB); load2(8'd201, 12'h2D2);
        load2(8'd202, 12'hE00); load2(8'd203, 12'hF00); load2(8'd210, 12'hF60);
        run2 = 1'b1;
        for (int n = 0; n < 100 && halted2 !== 1'b1; n++) begin
            tick(1);
            if (out_valid2 === 1'b1) outs2.push_back(16'(out_value2));
        end
        check("w_halt", 32'(halted2), 32'd1);
        check("w_out", outs2.size() == 1 ? 32'(outs2[0]) : 32'hDEAD, 32'h00B);
        check("w_flags", {30'd0, carry2, zero2}, 32'b10);
        check("w_pc", 32'(pc2), 32'd204);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
